prio_arbiter_ctrl: RTL and testbench

- Sequencing and arbitration controller for a bank of NMEM per-memory readout support blocks.
- Each crossing, it issues the init pulse and the multi-cycle setup window to every support block.
- It then grants one-hot sel to the lowest-index memory whose has_dat is high, until all memories are drained.
- It tags each read item with its source index, aligned to the memory read latency, for the downstream merger.

---
 rtl/prio_arbiter_ctrl.sv | 159 +++++++++++++++
 tb/tb_prio_arbiter_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_ctrl.sv
// Crossing sequencer and fixed-priority readout arbiter for NMEM memory support blocks.
// Issues init/setup, grants the lowest non-empty channel, and tags read data with its source index.
module prio_arbiter_ctrl #(
  parameter int unsigned NMEM      = 8,
  parameter int unsigned IDXW      = 3,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [NMEM-1:0] has_dat,
  input  logic [NMEM-1:0] valid,
  output logic            init,
  output logic            setup,
  output logic [NMEM-1:0] sel,
  output logic            out_vld,
  output logic [IDXW-1:0] out_idx,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned CNT_MAX = (SETUP_CYC > RD_LAT + 1) ? SETUP_CYC : RD_LAT + 1;
  localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SETUP,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t                      state_q, state_d;
  logic [CNTW-1:0]             cnt_q, cnt_d;
  logic                        init_q, init_d;
  logic                        setup_q, setup_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic [RD_LAT-1:0]           vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][IDXW-1:0] idx_pipe_q, idx_pipe_d;

  logic [NMEM-1:0] lsb_oh;
  logic [IDXW-1:0] enc_idx;
  logic            enc_found;
  logic            multi_vld;
  logic            cap_vld;

  // Fixed priority grant: isolate the lowest set bit of has_dat.
  always_comb begin
    lsb_oh = has_dat & (~has_dat + NMEM'(1));
    sel    = (state_q == ST_RUN) ? lsb_oh : '0;
  end

  // Lowest-index encoder for the read-issued flags.
  always_comb begin
    enc_idx   = '0;
    enc_found = 1'b0;
    for (int i = 0; i < int'(NMEM); i++) begin
      if (valid[i] && !enc_found) begin
        enc_idx   = IDXW'(i);
        enc_found = 1'b1;
      end
    end
  end

  assign multi_vld = (valid & (valid - NMEM'(1))) != '0;
  // Valids arriving during INIT are stragglers of an aborted crossing's last grant.
  assign cap_vld   = (|valid) && (state_q != ST_INIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (start) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_INIT: begin
          state_d = ST_SETUP;
          cnt_d   = CNTW'(SETUP_CYC - 1);
        end
        ST_SETUP: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNTW'(1);
        end
        ST_RUN: begin
          if (has_dat == '0) begin
            state_d = ST_DRAIN;
            cnt_d   = CNTW'(RD_LAT);
          end
        end
        ST_DRAIN: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    init_d  = (state_d == ST_INIT);
    setup_d = (state_d == ST_SETUP);
    busy_d  = (state_d != ST_IDLE);
    err_d   = start ? 1'b0 : (err_q | multi_vld);
  end

  // Read-latency alignment pipeline; start flushes it.
  always_comb begin
    vld_pipe_d = '0;
    idx_pipe_d = '0;
    if (!start) begin
      vld_pipe_d[0] = cap_vld;
      idx_pipe_d[0] = cap_vld ? enc_idx : '0;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_pipe_d[i] = vld_pipe_q[i-1];
        idx_pipe_d[i] = idx_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      init_q     <= 1'b0;
      setup_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_q     <= init_d;
      setup_q    <= setup_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
      idx_pipe_q <= idx_pipe_d;
    end
  end

  assign init    = init_q;
  assign setup   = setup_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign out_vld = vld_pipe_q[RD_LAT-1];
  assign out_idx = idx_pipe_q[RD_LAT-1];

endmodule

// File: tb/tb_prio_arbiter_ctrl.sv
// Self-checking bench for prio_arbiter_ctrl: models the support blocks and predicts each
// crossing's full timeline from the channel counts.
module tb_prio_arbiter_ctrl;

  localparam int unsigned NMEM      = 8;
  localparam int unsigned IDXW      = 3;
  localparam int unsigned SETUP_CYC = 2;
  localparam int unsigned RD_LAT    = 2;
  localparam int          MAXC      = 80;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [NMEM-1:0] has_dat;
  logic [NMEM-1:0] valid;
  logic [NMEM-1:0] mvalid;
  logic [NMEM-1:0] force_valid;
  logic            init, setup, out_vld, busy, done, err;
  logic [NMEM-1:0] sel;
  logic [IDXW-1:0] out_idx;

  int unsigned cnt      [NMEM];
  int unsigned load_cnt [NMEM];

  int n_checks = 0;
  int n_fail   = 0;

  logic [NMEM-1:0] e_sel  [MAXC];
  logic            e_init [MAXC];
  logic            e_setup[MAXC];
  logic            e_busy [MAXC];
  logic            e_done [MAXC];
  logic            e_vld  [MAXC];
  logic [IDXW-1:0] e_idx  [MAXC];
  int              e_last;

  always #5 clk = ~clk;

  assign valid = mvalid | force_valid;

  prio_arbiter_ctrl #(
    .NMEM(NMEM), .IDXW(IDXW), .SETUP_CYC(SETUP_CYC), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .has_dat(has_dat), .valid(valid),
    .init(init), .setup(setup), .sel(sel), .out_vld(out_vld), .out_idx(out_idx),
    .busy(busy), .done(done), .err(err)
  );

  // Support blocks: load on init, read one item per granted cycle, flags registered.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mvalid  <= '0;
      has_dat <= '0;
      for (int i = 0; i < int'(NMEM); i++) cnt[i] <= 0;
    end else begin
      for (int i = 0; i < int'(NMEM); i++) begin
        mvalid[i]  <= sel[i] && (cnt[i] != 0);
        has_dat[i] <= (cnt[i] != 0);
        if (init) cnt[i] <= load_cnt[i];
        else if (sel[i] && cnt[i] != 0) cnt[i] <= cnt[i] - 1;
      end
    end
  end

  // Timeline of a crossing, cycle 0 = the start cycle.
  function automatic void build_expect();
    int t;
    int dn;
    for (int k = 0; k < MAXC; k++) begin
      e_sel[k] = '0; e_init[k] = 1'b0; e_setup[k] = 1'b0; e_busy[k] = 1'b0;
      e_done[k] = 1'b0; e_vld[k] = 1'b0; e_idx[k] = '0;
    end
    e_init[1] = 1'b1;
    for (int k = 2; k < 2 + int'(SETUP_CYC); k++) e_setup[k] = 1'b1;
    t = 2 + int'(SETUP_CYC);
    for (int i = 0; i < int'(NMEM); i++) begin
      if (load_cnt[i] > 0) begin
        for (int j = 0; j <= int'(load_cnt[i]); j++) e_sel[t+j] = NMEM'(1) << i;
        for (int j = 1; j <= int'(load_cnt[i]); j++) begin
          e_vld[t+j+int'(RD_LAT)] = 1'b1;
          e_idx[t+j+int'(RD_LAT)] = IDXW'(i);
        end
        t = t + int'(load_cnt[i]) + 1;
      end
    end
    dn = t + int'(RD_LAT) + 2;
    e_done[dn] = 1'b1;
    for (int k = 1; k < dn; k++) e_busy[k] = 1'b1;
    e_last = dn + 1;
  endfunction

  task automatic do_crossing(input bit chk0, input string tag);
    build_expect();
    @(posedge clk); #1 start = 1'b1;
    for (int k = 0; k <= e_last; k++) begin
      if (k > 0) begin
        @(posedge clk); #1 start = 1'b0;
      end
      @(negedge clk);
      if (k > 0 || chk0) begin
        n_checks += 7;
        if (sel !== e_sel[k]) begin
          n_fail++; $display("FAIL %s sel c%0d: got %h exp %h", tag, k, sel, e_sel[k]);
        end
        if (init !== e_init[k]) begin
          n_fail++; $display("FAIL %s init c%0d: got %b exp %b", tag, k, init, e_init[k]);
        end
        if (setup !== e_setup[k]) begin
          n_fail++; $display("FAIL %s setup c%0d: got %b exp %b", tag, k, setup, e_setup[k]);
        end
        if (busy !== e_busy[k]) begin
          n_fail++; $display("FAIL %s busy c%0d: got %b exp %b", tag, k, busy, e_busy[k]);
        end
        if (done !== e_done[k]) begin
          n_fail++; $display("FAIL %s done c%0d: got %b exp %b", tag, k, done, e_done[k]);
        end
        if (out_vld !== e_vld[k]) begin
          n_fail++; $display("FAIL %s out_vld c%0d: got %b exp %b", tag, k, out_vld, e_vld[k]);
        end
        if (out_idx !== e_idx[k]) begin
          n_fail++; $display("FAIL %s out_idx c%0d: got %0d exp %0d", tag, k, out_idx, e_idx[k]);
        end
      end
      if (k > 0) begin
        n_checks++;
        if (err !== 1'b0) begin
          n_fail++; $display("FAIL %s err c%0d: got %b exp 0", tag, k, err);
        end
      end
    end
  endtask

  task automatic set_counts(input int unsigned c0, c1, c2, c3, c4, c5, c6, c7);
    load_cnt[0] = c0; load_cnt[1] = c1; load_cnt[2] = c2; load_cnt[3] = c3;
    load_cnt[4] = c4; load_cnt[5] = c5; load_cnt[6] = c6; load_cnt[7] = c7;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; force_valid = '0;
    set_counts(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    n_checks++;
    if ({init, setup, sel, out_vld, out_idx, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got init=%b setup=%b sel=%h vld=%b idx=%0d busy=%b done=%b err=%b exp all 0",
               init, setup, sel, out_vld, out_idx, busy, done, err);
    end
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, sel, out_vld} !== '0) begin
      n_fail++; $display("FAIL reset_idle: got busy=%b sel=%h vld=%b exp 0", busy, sel, out_vld);
    end
  endtask

  task automatic test_basic_drain();
    set_counts(3, 0, 1, 0, 0, 2, 0, 0);
    do_crossing(1'b1, "basic");
  endtask

  task automatic test_all_zero();
    set_counts(0, 0, 0, 0, 0, 0, 0, 0);
    do_crossing(1'b1, "all_zero");
  endtask

  task automatic test_priority_sweep();
    set_counts(1, 1, 1, 1, 1, 1, 1, 1);
    do_crossing(1'b1, "sweep");
  endtask

  task automatic test_abort();
    set_counts(0, 5, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (sel !== 8'h02 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_mid: got sel=%h busy=%b exp sel=02 busy=1", sel, busy);
    end
    set_counts(2, 0, 0, 1, 0, 0, 0, 0);
    do_crossing(1'b0, "abort");
  endtask

  task automatic test_async_reset();
    set_counts(6, 0, 0, 0, 0, 0, 0, 0);
    build_expect();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_vld !== e_vld[8] || sel !== e_sel[8]) begin
      n_fail++; $display("FAIL rst_pre: got vld=%b sel=%h exp vld=%b sel=%h", out_vld, sel, e_vld[8], e_sel[8]);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({sel, busy, out_vld, done, init} !== '0) begin
      n_fail++; $display("FAIL rst_async: got sel=%h busy=%b vld=%b done=%b init=%b exp 0",
                         sel, busy, out_vld, done, init);
    end
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || init !== 1'b0) begin
      n_fail++; $display("FAIL rst_start_ignored: got busy=%b init=%b exp 0", busy, init);
    end
    reset = 1'b0;
    set_counts(1, 2, 0, 0, 3, 0, 0, 1);
    do_crossing(1'b1, "post_reset");
  endtask

  task automatic test_error_flag();
    @(posedge clk); #1 force_valid = 8'h09;
    @(posedge clk); #1 force_valid = 8'h00;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || out_vld !== 1'b0) begin
      n_fail++; $display("FAIL err_set: got err=%b vld=%b exp err=1 vld=0", err, out_vld);
    end
    @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b1 || out_idx !== 3'd0 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_fwd: got vld=%b idx=%0d err=%b exp 1 0 1", out_vld, out_idx, err);
    end
    @(posedge clk); #1 force_valid = 8'h0A;
    @(posedge clk); #1 force_valid = 8'h00;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b1 || out_idx !== 3'd1) begin
      n_fail++; $display("FAIL err_fwd2: got vld=%b idx=%0d exp 1 1", out_vld, out_idx);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || out_vld !== 1'b0 || out_idx !== 3'd0) begin
      n_fail++; $display("FAIL err_sticky: got err=%b vld=%b idx=%0d exp 1 0 0", err, out_vld, out_idx);
    end
    set_counts(0, 0, 2, 0, 0, 0, 1, 0);
    do_crossing(1'b1, "err_clear");
  endtask

  task automatic test_random_crossings();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < int'(NMEM); i++)
        load_cnt[i] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
      do_crossing(1'b1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_all_zero();
    test_priority_sweep();
    test_abort();
    test_async_reset();
    test_error_flag();
    test_random_crossings();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
